// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//
// Execute-to-memory pipeline stage. Takes the ALU's per-instruction bundle,
// decodes the writeback/memory controls, resolves beq/bne from the ALU zero
// flag, raises an overflow exception for signed add/sub/addi, and presents a
// registered, valid/ready handshaked bundle to the memory stage.
//
// A main output register plus one skid register absorb a single cycle of
// back-pressure, so a bundle accepted while the output is stalled is never
// lost. in_ready is simply "skid empty", which comes straight from a flop.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        upstream handshake (ALU side)
//   instruction, pc_plus4      executed instruction and its PC + 4
//   alu_result, alu_flags      ALU result and {zero, negative, overflow}
//   rt_data                    regB value (store data)
//   out_valid / out_ready      downstream handshake (memory side)
//   out_result, out_store_data registered result / store data
//   out_dest, out_reg_write    writeback index and enable
//   out_mem_read/out_mem_write lw / sw strobes
//   redirect_valid/redirect_pc one-cycle fetch redirect
//   exc_overflow               one-cycle pulse accompanying overflow redirect
// ---------------------------------------------------------------------------
module ex_mem_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instruction,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] alu_result,
    input  logic [2:0]  alu_flags,
    input  logic [31:0] rt_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [31:0] out_store_data,
    output logic [4:0]  out_dest,
    output logic        out_reg_write,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        exc_overflow
);

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  dest;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } bundle_t;

    // ------------------------------------------------------------------
    // Decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic [15:0] imm;

    assign opcode = instruction[31:26];
    assign funct  = instruction[5:0];
    assign rt_idx = instruction[20:16];
    assign rd_idx = instruction[15:11];
    assign imm    = instruction[15:0];

    logic        write_class;
    logic [4:0]  dec_dest;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        ovf_class;
    logic        is_beq;
    logic        is_bne;
    logic        exc_now;
    logic        taken_now;
    logic [31:0] branch_target;
    bundle_t     dec_bundle;

    always_comb begin
        write_class   = 1'b0;
        dec_dest      = 5'd0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        ovf_class     = 1'b0;
        is_beq        = 1'b0;
        is_bne        = 1'b0;
        case (opcode)
            6'h00: begin
                // R-type functions the ALU implements; anything else is a bubble
                case (funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2A, 6'h2B: begin
                        write_class = 1'b1;
                        dec_dest    = rd_idx;
                    end
                    default: ;
                endcase
                ovf_class = (funct == 6'h20) || (funct == 6'h22);
            end
            6'h08: begin
                write_class = 1'b1;
                dec_dest    = rt_idx;
                ovf_class   = 1'b1;
            end
            6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
                write_class = 1'b1;
                dec_dest    = rt_idx;
            end
            6'h23: begin
                write_class  = 1'b1;
                dec_dest     = rt_idx;
                dec_mem_read = 1'b1;
            end
            6'h2B:   dec_mem_write = 1'b1;
            6'h04:   is_beq = 1'b1;
            6'h05:   is_bne = 1'b1;
            default: ;
        endcase
    end

    assign exc_now   = ovf_class & alu_flags[0];
    assign taken_now = (is_beq & alu_flags[2]) | (is_bne & ~alu_flags[2]);
    // Sign-extended word offset; wraps modulo 2^32 naturally
    assign branch_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};

    always_comb begin
        dec_bundle.result     = alu_result;
        dec_bundle.store_data = rt_data;
        dec_bundle.dest       = dec_dest;
        dec_bundle.reg_write  = write_class & (dec_dest != 5'd0) & ~exc_now;
        dec_bundle.mem_read   = dec_mem_read;
        dec_bundle.mem_write  = dec_mem_write;
    end

    // ------------------------------------------------------------------
    // Main + skid buffer and redirect registers
    // ------------------------------------------------------------------
    logic        main_valid_q, main_valid_d;
    bundle_t     main_q, main_d;
    logic        skid_valid_q, skid_valid_d;
    bundle_t     skid_q, skid_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        exc_overflow_q, exc_overflow_d;

    logic accept;
    logic drain;

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign drain    = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;

        if (skid_valid_q) begin
            // Full: nothing is accepted; a drain promotes the skid entry
            if (drain) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q || out_ready) begin
                main_valid_d = 1'b1;
                main_d       = dec_bundle;
            end else begin
                skid_valid_d = 1'b1;
                skid_d       = dec_bundle;
            end
        end else if (drain) begin
            main_valid_d = 1'b0;
        end

        // Redirects are decided at acceptance, regardless of where the bundle lands
        redirect_valid_d = accept & (exc_now | taken_now);
        exc_overflow_d   = accept & exc_now;
        redirect_pc_d    = redirect_pc_q;
        if (accept && (exc_now || taken_now)) begin
            redirect_pc_d = exc_now ? RESET_VECTOR : branch_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q     <= 1'b0;
            main_q           <= '0;
            skid_valid_q     <= 1'b0;
            skid_q           <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            exc_overflow_q   <= 1'b0;
        end else begin
            main_valid_q     <= main_valid_d;
            main_q           <= main_d;
            skid_valid_q     <= skid_valid_d;
            skid_q           <= skid_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            exc_overflow_q   <= exc_overflow_d;
        end
    end

    assign out_valid      = main_valid_q;
    assign out_result     = main_q.result;
    assign out_store_data = main_q.store_data;
    assign out_dest       = main_q.dest;
    assign out_reg_write  = main_q.reg_write;
    assign out_mem_read   = main_q.mem_read;
    assign out_mem_write  = main_q.mem_write;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign exc_overflow   = exc_overflow_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage
//
// Self-checking bench for ex_mem_stage. A behavioural model (a FIFO of
// expected bundles with capacity two, plus the expected redirect for the
// following cycle) is updated on each rising edge; one compare process checks
// every DUT output against it on each falling edge. Directed vectors pin the
// model against hand-computed values, then randomized traffic, a stall burst
// and a reset-while-full case are run.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage;

    localparam logic [31:0] RV = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] pc_plus4;
    logic [31:0] alu_result;
    logic [2:0]  alu_flags;
    logic [31:0] rt_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [31:0] out_store_data;
    logic [4:0]  out_dest;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_overflow;

    ex_mem_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .instruction    (instruction),
        .pc_plus4       (pc_plus4),
        .alu_result     (alu_result),
        .alu_flags      (alu_flags),
        .rt_data        (rt_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_store_data (out_store_data),
        .out_dest       (out_dest),
        .out_reg_write  (out_reg_write),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_overflow   (exc_overflow)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  dest;
        logic        rw;
        logic        mr;
        logic        mw;
    } bun_t;

    typedef struct packed {
        bun_t        b;
        logic        rv;
        logic [31:0] rpc;
        logic        exc;
    } exp_t;

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] res, input logic [31:0] rtd,
                                   input logic [2:0] flags);
        exp_t e;
        int unsigned op;
        int unsigned fn;
        bit writes;
        int signed off;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        e = '0;
        writes = 1'b0;
        e.b.result = res;
        e.b.store_data = rtd;
        if (op == 0 && fn inside {0, 2, 3, 4, 6, 7, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43}) begin
            writes = 1'b1;
            e.b.dest = ins[15:11];
        end else if (op inside {8, 9, 10, 11, 12, 13, 14, 35}) begin
            writes = 1'b1;
            e.b.dest = ins[20:16];
        end
        e.b.mr = (op == 35);
        e.b.mw = (op == 43);
        e.exc = flags[0] && ((op == 0 && (fn == 32 || fn == 34)) || op == 8);
        e.b.rw = writes && e.b.dest != 0 && !e.exc;
        off = int'($signed(ins[15:0]));
        if (e.exc) begin
            e.rv = 1'b1;
            e.rpc = RV;
        end else if ((op == 4 && flags[2]) || (op == 5 && !flags[2])) begin
            e.rv = 1'b1;
            e.rpc = pc + 32'(off * 4);
        end
        return e;
    endfunction

    bun_t        q[$];
    logic        exp_rv;
    logic [31:0] exp_rpc;
    logic        exp_exc;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_txn = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each rising edge; cleared by reset
    initial begin
        exp_rv = 1'b0;
        exp_rpc = 32'd0;
        exp_exc = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                exp_rv = 1'b0;
                exp_exc = 1'b0;
            end else begin
                exp_t e;
                bit acc;
                acc = in_valid && (q.size() < 2);
                e = model(instruction, pc_plus4, alu_result, rt_data, alu_flags);
                if (q.size() > 0 && out_ready) begin
                    $display("txn %0d: result=%h store=%h dest=%0d rw=%b mr=%b mw=%b",
                             n_txn, q[0].result, q[0].store_data, q[0].dest,
                             q[0].rw, q[0].mr, q[0].mw);
                    n_txn++;
                    void'(q.pop_front());
                end
                if (acc) q.push_back(e.b);
                exp_rv = acc && e.rv;
                exp_exc = acc && e.exc;
                if (acc && e.rv) exp_rpc = e.rpc;
            end
        end
    end

    // Compare process: every falling edge while out of reset
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("out_valid", 32'(out_valid), 32'(q.size() > 0));
                check("in_ready", 32'(in_ready), 32'(q.size() < 2));
                check("redirect_valid", 32'(redirect_valid), 32'(exp_rv));
                check("exc_overflow", 32'(exc_overflow), 32'(exp_exc));
                if (exp_rv) check("redirect_pc", redirect_pc, exp_rpc);
                if (q.size() > 0) begin
                    check("out_result", out_result, q[0].result);
                    check("out_store_data", out_store_data, q[0].store_data);
                    check("out_dest", 32'(out_dest), 32'(q[0].dest));
                    check("out_reg_write", 32'(out_reg_write), 32'(q[0].rw));
                    check("out_mem_read", 32'(out_mem_read), 32'(q[0].mr));
                    check("out_mem_write", 32'(out_mem_write), 32'(q[0].mw));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] res;
        logic [31:0] rtd;
        logic [2:0]  flags;
        logic [4:0]  dest;
        logic        rw;
        logic        mw;
        logic        rv;
        logic [31:0] rpc;
        logic        exc;
    } vec_t;

    vec_t vecs[10];

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] res, input logic [31:0] rtd, input logic [2:0] fl);
        in_valid = v;
        instruction = ins;
        pc_plus4 = pc;
        alu_result = res;
        rt_data = rtd;
        alu_flags = fl;
    endtask

    function automatic logic [31:0] rand_ins();
        logic [5:0] ops[15];
        logic [5:0] fns[13];
        logic [31:0] w;
        ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F};
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                6'h2A, 6'h2B, 6'h00, 6'h03, 6'h08};
        w = $urandom;
        w[31:26] = ops[$urandom_range(0, 14)];
        if (w[31:26] == 6'h3F) w[31:26] = 6'($urandom);
        if (w[31:26] == 6'h00 && $urandom_range(0, 7) != 0) w[5:0] = fns[$urandom_range(0, 12)];
        return w;
    endfunction

    initial begin
        exp_t e;
        bit c_acc;
        // add, addi ovf, addiu, beq taken, beq not, bne taken, bne not, beq far, sw, addu rd=0
        vecs[0] = '{32'h00221820, 32'h100, 32'd5, 32'h0, 3'b000, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[1] = '{32'h2023FFFE, 32'h104, 32'h7, 32'h0, 3'b001, 5'd3, 1'b0, 1'b0, 1'b1, RV, 1'b1};
        vecs[2] = '{32'h2423FFFE, 32'h108, 32'h9, 32'h0, 3'b001, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[3] = '{32'h10200020, 32'h100, 32'h0, 32'h0, 3'b100, 5'd0, 1'b0, 1'b0, 1'b1, 32'h180, 1'b0};
        vecs[4] = '{32'h10200020, 32'h100, 32'h1, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[5] = '{32'h14200020, 32'h100, 32'h1, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1, 32'h180, 1'b0};
        vecs[6] = '{32'h14200020, 32'h100, 32'h0, 32'h0, 3'b100, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[7] = '{32'h10208000, 32'h100, 32'h0, 32'h0, 3'b100, 5'd0, 1'b0, 1'b0, 1'b1, 32'hFFFE0100, 1'b0};
        vecs[8] = '{32'hAC20FFFF, 32'h200, 32'hFFFFFFFC, 32'h1234, 3'b000, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0};
        vecs[9] = '{32'h00220021, 32'h204, 32'h3, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};

        rst_n = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000);
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_redirect", 32'(redirect_valid), 32'd0);
        check("rst_exc", 32'(exc_overflow), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_dest", 32'(out_dest), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: pin the model to literals, then run each through the DUT
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            e = model(vecs[i].ins, vecs[i].pc, vecs[i].res, vecs[i].rtd, vecs[i].flags);
            check("pin_dest", 32'(e.b.dest), 32'(vecs[i].dest));
            check("pin_rw", 32'(e.b.rw), 32'(vecs[i].rw));
            check("pin_mw", 32'(e.b.mw), 32'(vecs[i].mw));
            check("pin_rv", 32'(e.rv), 32'(vecs[i].rv));
            check("pin_exc", 32'(e.exc), 32'(vecs[i].exc));
            if (vecs[i].rv) check("pin_rpc", e.rpc, vecs[i].rpc);
            drive(1'b1, vecs[i].ins, vecs[i].pc, vecs[i].res, vecs[i].rtd, vecs[i].flags);
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000);
        @(negedge clk);

        // Stall burst: A, B, C back-to-back with out_ready low for four cycles
        out_ready = 1'b0;
        drive(1'b1, 32'h00221820, 32'h300, 32'hA, 32'h0, 3'b000);
        @(negedge clk);
        drive(1'b1, 32'h10200020, 32'h304, 32'hB, 32'h0, 3'b100);
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_held_a", out_result, 32'hA);
        drive(1'b1, 32'h8C450004, 32'h308, 32'hC, 32'h0, 3'b000);
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        c_acc = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (in_ready) begin
                c_acc = 1'b1;
                break;
            end
        end
        check("stall_c_accept", 32'(c_acc), 32'd1);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000);
        repeat (3) @(negedge clk);

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 3) != 0), rand_ins(), {$urandom_range(0, 32'h3FFFFFFF), 2'b00},
                  $urandom, $urandom, 3'($urandom));
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
        end

        // Reset while both entries are full and a redirect pulse is pending
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 32'h00221820, 32'h400, 32'h11, 32'h0, 3'b000);
        @(negedge clk);
        drive(1'b1, 32'h10200020, 32'h404, 32'h22, 32'h0, 3'b100);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_redirect", 32'(redirect_valid), 32'd0);
        check("midrst_out_result", out_result, 32'd0);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory pipeline stage that consumes the ALU's per-instruction output (instruction word, result, 3-bit flags, rt operand) and produces a registered, handshaked memory/writeback bundle. It decodes control (destination register, reg write, load/store), resolves beq/bne from the ALU zero flag, and raises an overflow exception for signed arithmetic. It also holds a two-entry skid buffer so back-pressure from the memory stage never drops an ALU result.

## Interface
- RESET_VECTOR, 32'h8000_0180, redirect PC issued on an overflow exception.

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  ALU output bundle valid
- in_ready  out  1  stage can accept a bundle
- instruction  in  32  instruction executed by the ALU
- pc_plus4  in  32  PC of that instruction + 4
- alu_result  in  32  ALU result (effective address for lw/sw)
- alu_flags  in  3  {zero, negative, overflow}
- rt_data  in  32  regB value (store data)
- out_valid  out  1  bundle valid toward memory stage
- out_ready  in  1  memory stage accepts bundle
- out_result  out  32  registered alu_result
- out_store_data  out  32  registered rt_data
- out_dest  out  5  writeback register index
- out_reg_write  out  1  writeback enable
- out_mem_read  out  1  lw
- out_mem_write  out  1  sw
- redirect_valid  out  1  one-cycle pulse: fetch must redirect
- redirect_pc  out  32  redirect target
- exc_overflow  out  1  one-cycle pulse with overflow redirect

## Operation
- Fields: opcode=[31:26], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0].
- Destination: opcode 0 -> rd; addi 08, addiu 09, slti 0A, sltiu 0B, andi 0C, ori 0D, xori 0E, lw 23 -> rt; sw 2B, beq 04, bne 05 -> no write.
- out_reg_write = write-class instruction AND dest != 0 AND not overflow-excepted. Unknown opcode/funct: bubble with all enables 0, still passed through.
- Overflow exception: (opcode 0 with funct 20 or 22) or opcode 08, with alu_flags[0]=1. Writeback suppressed; redirect to RESET_VECTOR, exc_overflow=1. addu/subu/addiu never except.
- Branch: beq taken iff alu_flags[2]=1; bne taken iff alu_flags[2]=0. Target = pc_plus4 + (sign_ext(imm)<<2), modulo 2^32. Taken branch -> redirect pulse with target; not-taken -> none.
- Redirect/exception decided at acceptance (in_valid & in_ready), independent of out_ready.
- Buffer: main output register plus one skid register. in_ready = skid empty (registered). Accept when main empty or draining -> main; accept while main held (out_valid & !out_ready) -> skid. On main drain, skid moves to main; in_ready returns 1 next cycle.
- Order strictly preserved; no bundle dropped or duplicated.

## Timing
- Reset (async, immediate): out_valid=0, in_ready=1, redirect_valid=0, exc_overflow=0, all data outputs 0, skid empty.
- Latency: accepted in cycle N -> out_valid with bundle in cycle N+1 when pipeline not stalled.
- redirect_valid/redirect_pc/exc_overflow registered: high exactly cycle N+1 for one cycle, even if bundle stalls in skid.
- Throughput: one bundle/cycle with out_ready held high.
- Stall: out_valid held, all out_* stable while out_ready=0.
- Full (main+skid occupied): in_ready=0; in_valid ignored.
- Simultaneous drain and accept with skid occupied: skid->main, new bundle -> skid is not allowed since in_ready was 0; in_ready rises the following cycle.
- Reset mid-stall: both entries discarded, pending redirect pulse cancelled.

## Test plan
- add, instr 0x00221820, result 5, flags 000, out_ready=1 -> next cycle out_valid, out_dest=3, out_reg_write=1, out_result=5, no redirect.
- addi 0x2023FFFE with flags 001 -> out_reg_write=0, redirect_valid=1, redirect_pc=0x80000180, exc_overflow=1 for one cycle; same with addiu 0x2423FFFE -> no exception, out_reg_write=1.
- beq 0x10200020, pc_plus4=0x100, flags 100 -> redirect_pc=0x180; flags 000 -> no redirect; bne reverses; beq imm 0x8000 at pc_plus4=0x100 -> redirect_pc=0xFFFE0100.
- sw 0xAC20FFFF, result 0xFFFFFFFC, rt_data 0x1234 -> out_mem_write=1, out_reg_write=0, out_store_data=0x1234; addu with rd=0 -> out_reg_write=0.
- out_ready=0 for 4 cycles, 3 back-to-back bundles A,B,C -> A held, B in skid, in_ready=0, C stalled; release -> A,B,C emitted in order, nothing lost.
- rst_n low mid-stall with both entries full -> outputs immediately at reset values, in_ready=1 after release.
